// File: rtl/ysyx_041514_cache_mem_arbiter_pkg.sv
// Shared types for the cache/memory port arbiter.
// grant_o carries arb_state_e so the bridge and debug logic can decode it.
package ysyx_041514_cache_mem_arbiter_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 64;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'b00,
        ARB_GNT_IC = 2'b01,
        ARB_GNT_DC = 2'b10
    } arb_state_e;

    typedef enum logic {
        LAST_IC = 1'b0,
        LAST_DC = 1'b1
    } last_e;

    function automatic arb_state_e rr_pick(
        input logic  ic,
        input logic  dc,
        input last_e last
    );
        if (ic && dc) begin
            if (last == LAST_IC) return ARB_GNT_DC;
            else                 return ARB_GNT_IC;
        end else if (ic) begin
            return ARB_GNT_IC;
        end else if (dc) begin
            return ARB_GNT_DC;
        end
        return ARB_IDLE;
    endfunction

endpackage

// File: rtl/ysyx_041514_cache_mem_arbiter_if.sv
// Cache-side and memory-side signals of the arbiter.
// master: the arbiter itself; slave: caches plus memory bridge.
interface ysyx_041514_cache_mem_arbiter_if #(
    parameter int ADDR_W = ysyx_041514_cache_mem_arbiter_pkg::ARB_ADDR_W,
    parameter int DATA_W = ysyx_041514_cache_mem_arbiter_pkg::ARB_DATA_W
);
    logic [ADDR_W-1:0] ic_raddr_i;
    logic              ic_raddr_valid_i;
    logic [7:0]        ic_rmask_i;
    logic [3:0]        ic_rsize_i;
    logic [7:0]        ic_rlen_i;
    logic              ic_rdata_ready_o;
    logic [DATA_W-1:0] ic_rdata_o;

    logic [ADDR_W-1:0] dc_addr_i;
    logic              dc_valid_i;
    logic              dc_wen_i;
    logic [7:0]        dc_mask_i;
    logic [3:0]        dc_size_i;
    logic [7:0]        dc_len_i;
    logic [DATA_W-1:0] dc_wdata_i;
    logic              dc_ready_o;
    logic [DATA_W-1:0] dc_rdata_o;

    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_valid_o;
    logic              mem_wen_o;
    logic [7:0]        mem_mask_o;
    logic [3:0]        mem_size_o;
    logic [7:0]        mem_len_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_ready_i;
    logic [DATA_W-1:0] mem_rdata_i;

    logic [1:0]        grant_o;

    modport master (
        input  ic_raddr_i, ic_raddr_valid_i, ic_rmask_i,
        input  ic_rsize_i, ic_rlen_i,
        output ic_rdata_ready_o, ic_rdata_o,
        input  dc_addr_i, dc_valid_i, dc_wen_i, dc_mask_i,
        input  dc_size_i, dc_len_i, dc_wdata_i,
        output dc_ready_o, dc_rdata_o,
        output mem_addr_o, mem_valid_o, mem_wen_o, mem_mask_o,
        output mem_size_o, mem_len_o, mem_wdata_o,
        input  mem_ready_i, mem_rdata_i,
        output grant_o
    );

    modport slave (
        output ic_raddr_i, ic_raddr_valid_i, ic_rmask_i,
        output ic_rsize_i, ic_rlen_i,
        input  ic_rdata_ready_o, ic_rdata_o,
        output dc_addr_i, dc_valid_i, dc_wen_i, dc_mask_i,
        output dc_size_i, dc_len_i, dc_wdata_i,
        input  dc_ready_o, dc_rdata_o,
        input  mem_addr_o, mem_valid_o, mem_wen_o, mem_mask_o,
        input  mem_size_o, mem_len_o, mem_wdata_o,
        output mem_ready_i, mem_rdata_i,
        input  grant_o
    );

endinterface

// File: rtl/ysyx_041514_cache_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between icache and dcache.
// The port is locked for a whole burst; beats are counted against len.
module ysyx_041514_cache_mem_arbiter
    import ysyx_041514_cache_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
) (
    input logic clk,
    input logic rst,
    ysyx_041514_cache_mem_arbiter_if.master bus
);

    arb_state_e state_q, state_d;
    last_e      last_q, last_d;
    logic [7:0] beat_cnt_q, beat_cnt_d;

    logic [ADDR_W-1:0] addr;
    logic              valid;
    logic              wen;
    logic [7:0]        mask;
    logic [3:0]        size;
    logic [7:0]        len;
    logic [DATA_W-1:0] wdata;
    logic              ic_ready;
    logic              dc_ready;
    logic [DATA_W-1:0] ic_rdata;
    logic [DATA_W-1:0] dc_rdata;
    logic              hs;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ARB_IDLE;
            last_q     <= LAST_IC;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        beat_cnt_d = beat_cnt_q;
        addr       = '0;
        valid      = 1'b0;
        wen        = 1'b0;
        mask       = '0;
        size       = '0;
        len        = '0;
        wdata      = '0;
        ic_ready   = 1'b0;
        dc_ready   = 1'b0;
        ic_rdata   = '0;
        dc_rdata   = '0;
        hs         = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                state_d = rr_pick(bus.ic_raddr_valid_i,
                                  bus.dc_valid_i, last_q);
                if (state_d == ARB_GNT_IC) begin
                    last_d     = LAST_IC;
                    beat_cnt_d = '0;
                end else if (state_d == ARB_GNT_DC) begin
                    last_d     = LAST_DC;
                    beat_cnt_d = '0;
                end
            end
            ARB_GNT_IC: begin
                addr     = bus.ic_raddr_i;
                valid    = bus.ic_raddr_valid_i;
                mask     = bus.ic_rmask_i;
                size     = bus.ic_rsize_i;
                len      = bus.ic_rlen_i;
                ic_ready = bus.mem_ready_i & valid;
                ic_rdata = bus.mem_rdata_i;
            end
            ARB_GNT_DC: begin
                addr     = bus.dc_addr_i;
                valid    = bus.dc_valid_i;
                wen      = bus.dc_wen_i;
                mask     = bus.dc_mask_i;
                size     = bus.dc_size_i;
                len      = bus.dc_len_i;
                wdata    = bus.dc_wdata_i;
                dc_ready = bus.mem_ready_i & valid;
                dc_rdata = bus.mem_rdata_i;
            end
            default: state_d = ARB_IDLE;
        endcase

        // valid is forced low in IDLE, so this only acts while granted
        hs = valid & bus.mem_ready_i;
        if (hs) begin
            if (beat_cnt_q == len) begin
                state_d    = ARB_IDLE;
                beat_cnt_d = '0;
            end else begin
                beat_cnt_d = beat_cnt_q + 8'd1;
            end
        end
    end

    assign bus.mem_addr_o       = addr;
    assign bus.mem_valid_o      = valid;
    assign bus.mem_wen_o        = wen;
    assign bus.mem_mask_o       = mask;
    assign bus.mem_size_o       = size;
    assign bus.mem_len_o        = len;
    assign bus.mem_wdata_o      = wdata;
    assign bus.ic_rdata_ready_o = ic_ready;
    assign bus.ic_rdata_o       = ic_rdata;
    assign bus.dc_ready_o       = dc_ready;
    assign bus.dc_rdata_o       = dc_rdata;
    assign bus.grant_o          = state_q;

endmodule

// File: doc/ysyx_041514_cache_mem_arbiter.md
Name: ysyx_041514_cache_mem_arbiter

Overview:
- Shares the single external memory port between the icache refill/uncache-read master and the dcache master (read refill, write-back, uncached read/write).
- Sits between both caches and the memory/AXI bridge.
- Locks the port for a whole burst, counts beats against the requester's length field, and alternates grants round-robin when both request together.

Parameters:
- ADDR_W, 32, address width (matches `ysyx_041514_NPC_ADDR_BUS`)
- DATA_W, 64, data width per beat (matches `ysyx_041514_XLEN_BUS`)

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- ic_raddr_i  in  ADDR_W  icache read address
- ic_raddr_valid_i  in  1  icache request/beat valid
- ic_rmask_i  in  8  icache read mask
- ic_rsize_i  in  4  icache beat size
- ic_rlen_i  in  8  icache burst length minus 1
- ic_rdata_ready_o  out  1  icache beat handshake
- ic_rdata_o  out  DATA_W  icache read data
- dc_addr_i  in  ADDR_W  dcache address
- dc_valid_i  in  1  dcache request/beat valid
- dc_wen_i  in  1  1 = write, 0 = read
- dc_mask_i  in  8  dcache byte mask
- dc_size_i  in  4  dcache beat size
- dc_len_i  in  8  dcache burst length minus 1
- dc_wdata_i  in  DATA_W  dcache write data, current beat
- dc_ready_o  out  1  dcache beat handshake
- dc_rdata_o  out  DATA_W  dcache read data
- mem_addr_o  out  ADDR_W  address to memory
- mem_valid_o  out  1  memory request/beat valid
- mem_wen_o  out  1  write enable
- mem_mask_o  out  8  byte mask
- mem_size_o  out  4  beat size
- mem_len_o  out  8  burst length minus 1
- mem_wdata_o  out  DATA_W  write data
- mem_ready_i  in  1  memory beat handshake
- mem_rdata_i  in  DATA_W  memory read data
- grant_o  out  2  current grant: 00 none, 01 icache, 10 dcache

Behaviour:
- States: IDLE, GNT_IC, GNT_DC. All state is held in flops cleared asynchronously when rst = 0.
- Reset values:
  - state = IDLE, beat_cnt = 0, last_grant = icache.
  - All outputs 0: mem_valid_o, mem_wen_o, mem_addr_o, mem_mask_o, mem_size_o, mem_len_o, mem_wdata_o, both ready outputs, grant_o.
- IDLE: nothing is forwarded; mem_valid_o = 0 and both ready outputs = 0. Next-state rules:
  - only ic_raddr_valid_i high -> GNT_IC
  - only dc_valid_i high -> GNT_DC
  - both high -> grant the master that is not last_grant
  - grant is taken at the next edge, so a request sees a 1-cycle arbitration bubble
  - on entry to a grant state, beat_cnt is cleared and last_grant is updated
- GNT_IC:
  - mem_addr/size/mask/len come combinationally from the ic_* inputs; mem_valid_o = ic_raddr_valid_i; mem_wen_o = 0; mem_wdata_o = 0.
  - ic_rdata_ready_o = mem_ready_i & mem_valid_o; ic_rdata_o = mem_rdata_i; dc_ready_o = 0.
- GNT_DC: same routing from the dc_* inputs, with mem_wen_o = dc_wen_i and mem_wdata_o = dc_wdata_i. dc_rdata_o = mem_rdata_i; ic_rdata_ready_o = 0.
- Ungranted master: its rdata output reads 0.
- Beat handshake = mem_valid_o & mem_ready_i. Each handshake increments beat_cnt (8 bit).
- A handshake with beat_cnt == granted len (len is sampled live; requesters hold fields stable for the whole burst) -> IDLE at the next edge, beat_cnt -> 0.
- len = 0 is a single beat: grant lasts exactly one handshake.
- Requester drops valid mid-burst (protocol violation): grant is held, no beats are counted, and mem_valid_o follows the requester low. The arbiter does not abort.
- Requesters drop valid in the cycle after their last beat. The arbiter is back in IDLE that cycle and must not regrant on the stale valid; since valid is already low, no special case is needed.
- Back-to-back requests: the same master re-requesting while the other waits loses the tie (round-robin). The minimum gap between bursts is 1 IDLE cycle.
- grant_o mirrors the state encoding.
- Async reset mid-burst: outputs drop to 0 immediately, without waiting for a clock edge. Memory-side cleanup is the bridge's responsibility via the same reset.

Decomposition:
- Shared header: widths come from sysconfig.v (`ysyx_041514_NPC_ADDR_BUS`, `ysyx_041514_XLEN_BUS`, TRUE/FALSE).
- Add state encodings ARB_IDLE/ARB_GNT_IC/ARB_GNT_DC to sysconfig.v so the bridge and debug logic can decode grant_o.
- No sub-module: the round-robin pick is two gates and is kept inline.

Test Plan:
- Icache burst alone: ic_raddr_valid_i = 1, ic_raddr_i = 0x8000_0040, ic_rlen_i = 7, mem_ready_i = 1 continuously -> grant_o = 01 one cycle later; 8 ic handshakes; mem_addr_o = 0x8000_0040 throughout; IDLE after the 8th beat; dc_ready_o stays 0.
- Dcache 4-beat write-back: dc_wen_i = 1, dc_len_i = 3, wdata 0x11..0x44 -> mem_wen_o = 1 and mem_wdata_o matches each beat; grant releases after the 4th handshake.
- Simultaneous requests after reset: ic and dc both valid in cycle 0 -> dcache granted first (last_grant reset = icache); icache granted in the IDLE cycle following dcache's last beat.
- Wait states: mem_ready_i low for 3 cycles between beats of a len = 1 read -> beat_cnt holds; exactly 2 ic handshakes; ic_rdata_o equals mem_rdata_i on each handshake.
- Uncached single beat: dc_len_i = 0, dc_wen_i = 0, addr 0xA000_0004 -> one handshake, dc_rdata_o = mem_rdata_i, then IDLE.
- Reset mid-burst: assert rst low during beat 3 of an 8-beat icache burst, off clock edge -> mem_valid_o and grant_o go 0 asynchronously. After release, a new request is granted normally with beat_cnt starting at 0.
